// File: rtl/syn_forward_scoreboard.sv
// Forwarding/hazard scoreboard for a short in-order pipeline.
// Tracks the destination register of each in-flight instruction behind ID
// (entry 1 = youngest, entry DEPTH = oldest). For each source operand it
// reports the youngest producer to forward from. It raises a stall when that
// producer is a load whose data is not yet available.
module syn_forward_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int REG_BITS   = 5,
    parameter int LOAD_READY = 2,
    parameter int SEL_BITS   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [REG_BITS-1:0] req_a,
    input  logic [REG_BITS-1:0] req_b,
    input  logic [REG_BITS-1:0] req_w,
    input  logic                w_en_id,
    input  logic                is_load_id,
    input  logic                flush,
    output logic [SEL_BITS-1:0] fwd_sel_a,
    output logic [SEL_BITS-1:0] fwd_sel_b,
    output logic                stall,
    output logic [15:0]         stall_count
);

    // Entry state. The valid bit already folds in the producer's write
    // enable, so a valid entry always denotes a pending register write.
    logic [DEPTH:1]        r_valid;
    logic [DEPTH:1]        r_load;
    logic [REG_BITS-1:0]   r_dest [1:DEPTH];
    logic [15:0]           r_stall_count;

    // Per-entry next values and source matches.
    logic [DEPTH:1]        w_valid_next;
    logic [DEPTH:1]        w_load_next;
    logic [REG_BITS-1:0]   w_dest_next [1:DEPTH];
    logic [DEPTH:1]        w_match_a;
    logic [DEPTH:1]        w_match_b;

    logic [SEL_BITS-1:0]   w_sel_a;
    logic [SEL_BITS-1:0]   w_sel_b;
    logic                  w_late_a;
    logic                  w_late_b;
    logic                  w_hazard;
    logic                  w_stall;
    logic                  w_issue;

    // Register 0 is hard-wired, so a zero source never matches anything.
    logic                  w_src_a_live;
    logic                  w_src_b_live;

    assign w_src_a_live = (req_a != '0);
    assign w_src_b_live = (req_b != '0);

    // The ID instruction enters EX only when it is neither stalled nor
    // squashed; otherwise a bubble is inserted behind the older entries.
    assign w_issue = !w_hazard && !flush;

    genvar gi;
    generate
        for (gi = 1; gi <= DEPTH; gi++) begin : g_entry
            assign w_match_a[gi] = r_valid[gi] && w_src_a_live &&
                                   (r_dest[gi] == req_a);
            assign w_match_b[gi] = r_valid[gi] && w_src_b_live &&
                                   (r_dest[gi] == req_b);

            if (gi == 1) begin : g_head
                assign w_valid_next[gi] = w_issue && w_en_id;
                assign w_load_next[gi]  = w_issue && is_load_id;
                assign w_dest_next[gi]  = req_w;
            end else begin : g_body
                assign w_valid_next[gi] = r_valid[gi-1];
                assign w_load_next[gi]  = r_load[gi-1];
                assign w_dest_next[gi]  = r_dest[gi-1];
            end
        end
    endgenerate

    // Youngest-producer select for operand A: scan oldest to youngest so the
    // smallest matching index is the one left standing.
    always_comb begin
        w_sel_a  = '0;
        w_late_a = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (w_match_a[k]) begin
                w_sel_a  = SEL_BITS'(k);
                w_late_a = r_load[k] && (k < LOAD_READY);
            end
        end
    end

    // Youngest-producer select for operand B, same rule as operand A.
    always_comb begin
        w_sel_b  = '0;
        w_late_b = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (w_match_b[k]) begin
                w_sel_b  = SEL_BITS'(k);
                w_late_b = r_load[k] && (k < LOAD_READY);
            end
        end
    end

    // A flush discards the ID instruction, so its dependency no longer matters.
    assign w_hazard = w_late_a || w_late_b;
    assign w_stall  = w_hazard && !flush;

    // Advance the scoreboard one stage per enabled cycle; en=0 freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_load  <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_dest[k] <= '0;
            end
        end else if (en) begin
            r_valid <= w_valid_next;
            r_load  <= w_load_next;
            for (int k = 1; k <= DEPTH; k++) begin
                r_dest[k] <= w_dest_next[k];
            end
        end
    end

    // Saturating count of enabled stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (en && w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign fwd_sel_a   = w_sel_a;
    assign fwd_sel_b   = w_sel_b;
    assign stall       = w_stall;
    assign stall_count = r_stall_count;

endmodule

// File: doc/syn_forward_scoreboard.md
SYN_FORWARD_SCOREBOARD -- requirements
Module: syn_forward_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3: number of in-flight stages tracked behind ID (entry 1 = EX, entry 2 = DM, entry 3 = WB); legal range 1..7.
REQ-002 Parameter REG_BITS, default 5: register index width.
REQ-003 Parameter LOAD_READY, default 2: lowest entry index at which a load's data can be forwarded; legal range 1..DEPTH.
REQ-004 Parameter SEL_BITS, default 2: forward-select width; SHALL satisfy 2^SEL_BITS > DEPTH.
REQ-005 Reset and clock: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 en  in  1  global enable; 0 freezes all state.
REQ-009 req_a, req_b  in  REG_BITS  source registers of the instruction in ID.
REQ-010 req_w  in  REG_BITS  destination register of the instruction in ID.
REQ-011 w_en_id  in  1  instruction in ID writes req_w.
REQ-012 is_load_id  in  1  instruction in ID is a data-memory load.
REQ-013 flush  in  1  taken jump/branch resolved in EX; squash the instruction in ID.
REQ-014 fwd_sel_a, fwd_sel_b  out  SEL_BITS  0 = register-file value, k = value of entry k.
REQ-015 stall  out  1  hold PC and IF/ID, insert bubble into EX.
REQ-016 stall_count  out  16  saturating count of stall cycles.

Function
REQ-017 Each entry k SHALL hold valid, dest (REG_BITS), load flag.
REQ-018 An entry k SHALL match source s when valid && w_en-recorded && dest == s && s != 0.
REQ-019 fwd_sel_x SHALL be the smallest matching k (youngest producer wins), else 0; combinational from current entries and req_x.
REQ-020 hazard SHALL be 1 when the youngest match for req_a or req_b has load flag set and index k < LOAD_READY.
REQ-021 stall SHALL equal hazard && !flush; combinational.
REQ-022 When en && !stall && !flush: entry 1 SHALL receive {valid=w_en_id, dest=req_w, load=is_load_id}; entry k+1 <= entry k for k = 1..DEPTH-1; entry DEPTH retires.
REQ-023 When en && (stall || flush): entry 1 SHALL receive a bubble (valid=0); older entries shift as in REQ-022.
REQ-024 flush SHALL take precedence over stall; the ID instruction is discarded, not held.
REQ-025 When en=0: no entry, counter, or shift SHALL change; outputs still track inputs combinationally.
REQ-026 stall_count SHALL increment by 1 each enabled cycle with stall=1 and saturate at 16'hFFFF.
REQ-027 Latency: a producer issued at cycle N SHALL be visible as entry 1 at cycle N+1 and entry k at cycle N+k; it SHALL not be visible after cycle N+DEPTH.
REQ-028 A write to register 0 SHALL never cause forwarding or stall.
REQ-029 req_a == req_b matching the same entry SHALL give equal fwd_sel_a and fwd_sel_b.
REQ-030 The block SHALL impose no constraint on its own inputs.

Reset
REQ-031 On rst_n=0, all entries SHALL become invalid immediately; fwd_sel_a=fwd_sel_b=0, stall=0, stall_count=0.
REQ-032 Reset asserted mid-stall SHALL clear the pending hazard; the first cycle after release SHALL show stall=0 for any inputs.

Verification
REQ-033 Back-to-back ALU: issue w_en_id=1, req_w=8; next cycle req_a=8 -> fwd_sel_a=1, stall=0; one cycle later req_b=8 -> fwd_sel_b=2.
REQ-034 Load-use: issue is_load_id=1, req_w=9; next cycle req_a=9 -> stall=1 for exactly one cycle, then fwd_sel_a=2, stall_count=1.
REQ-035 Youngest wins: entries 1 and 3 both dest=5 -> req_a=5 gives fwd_sel_a=1; req_a=0 with dest=0 in entry 1 gives fwd_sel_a=0.
REQ-036 Flush over stall: load-use hazard with flush=1 in the same cycle -> stall=0, entry 1 becomes a bubble, stall_count unchanged.
REQ-037 Freeze: hold en=0 for 4 cycles with a producer in entry 1 -> fwd_sel unchanged throughout; it moves to entry 2 on the first cycle with en=1.
REQ-038 Saturation and reset: force 65536 stall cycles -> stall_count=16'hFFFF; pulse rst_n low asynchronously -> all outputs 0 before the next clock edge.
